tug_scoreboard: RTL and testbench

Parametrised two-player score keeper for the tug-of-war game. Awards a point when the rope light reaches an end and that side's button is pressed. Holds the field reset for a programmable number of cycles after each point, and latches a match winner at a programmable target score. Drives one active-low 7-segment digit per player and blinks the winner's digit until a new match starts.

---
 rtl/tug_scoreboard.sv | 127 ++++++++++++
 tb/tb_tug_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tug_scoreboard.sv
// tug_scoreboard: tug-of-war score keeper with field-reset hold, match winner latch and blinking winner digit
module tug_scoreboard #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int BLINK_HALF  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               leftest,
    input  logic               L,
    input  logic               rightest,
    input  logic               R,
    input  logic               new_match,
    output logic               resetField,
    output logic [SCORE_W-1:0] score_h,
    output logic [SCORE_W-1:0] score_c,
    output logic [6:0]         display_h,
    output logic [6:0]         display_c,
    output logic [1:0]         winner,
    output logic               match_over
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_h_q, score_h_d, score_c_q, score_c_d;
    logic [1:0]         winner_q, winner_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               phase_q, phase_d;
    logic               hpt, cpt, in_over, blink_wrap, blank;
    logic [SCORE_W-1:0] inc_h, inc_c;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        hpt        = leftest & L & ~R;
        cpt        = rightest & R & ~L;
        inc_h      = score_h_q + 1'b1;
        inc_c      = score_c_q + 1'b1;
        in_over    = state_q == OVER;
        blink_wrap = blink_q == BLINK_LAST;
        state_d    = state_q;
        score_h_d  = score_h_q;
        score_c_d  = score_c_q;
        winner_d   = winner_q;
        hold_d     = hold_q;
        blink_d    = in_over ? (blink_wrap ? '0 : blink_q + 1'b1) : '0;
        phase_d    = in_over & (phase_q ^ blink_wrap);
        if (new_match) begin
            state_d   = HOLD;
            score_h_d = '0;
            score_c_d = '0;
            winner_d  = 2'b00;
            hold_d    = HOLD_INIT;
        end else if (state_q == PLAY && hpt) begin
            score_h_d = inc_h;
            state_d   = inc_h == WIN ? OVER : HOLD;
            winner_d  = inc_h == WIN ? 2'b01 : winner_q;
            hold_d    = HOLD_INIT;
        end else if (state_q == PLAY && cpt) begin
            score_c_d = inc_c;
            state_d   = inc_c == WIN ? OVER : HOLD;
            winner_d  = inc_c == WIN ? 2'b10 : winner_q;
            hold_d    = HOLD_INIT;
        end else if (state_q == HOLD) begin
            state_d = hold_q == '0 ? PLAY : HOLD;
            hold_d  = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            score_h_q <= '0;
            score_c_q <= '0;
            winner_q  <= 2'b00;
            hold_q    <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_h_q <= score_h_d;
            score_c_q <= score_c_d;
            winner_q  <= winner_d;
            hold_q    <= hold_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
        end
    end

    always_comb begin
        blank      = in_over & phase_q;
        resetField = state_q != PLAY;
        match_over = in_over;
        score_h    = score_h_q;
        score_c    = score_c_q;
        winner     = winner_q;
        display_h  = blank && winner_q == 2'b01 ? 7'b1111111 : seg7(4'(score_h_q));
        display_c  = blank && winner_q == 2'b10 ? 7'b1111111 : seg7(4'(score_c_q));
    end
endmodule

// File: tb/tb_tug_scoreboard.sv
// tb_tug_scoreboard: scoreboard bench for a default and a small-parameter tug_scoreboard
module tb_tug_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b0, leftest = 1'b0, L = 1'b0, rightest = 1'b0, R = 1'b0, new_match = 1'b0;
    logic rf_a, mo_a, rf_b, mo_b;
    logic [3:0] sh_a, sc_a;
    logic [1:0] sh_b, sc_b, w_a, w_b;
    logic [6:0] dh_a, dc_a, dh_b, dc_b;
    int n_tests = 0, n_fail = 0, rf_cnt;

    always #5 clk = ~clk;

    tug_scoreboard dut_a (
        .clk(clk), .reset(reset), .leftest(leftest), .L(L), .rightest(rightest), .R(R),
        .new_match(new_match), .resetField(rf_a), .score_h(sh_a), .score_c(sc_a),
        .display_h(dh_a), .display_c(dc_a), .winner(w_a), .match_over(mo_a)
    );

    tug_scoreboard #(.SCORE_W(2), .WIN_SCORE(3), .HOLD_CYCLES(1), .BLINK_HALF(8)) dut_b (
        .clk(clk), .reset(reset), .leftest(leftest), .L(L), .rightest(rightest), .R(R),
        .new_match(new_match), .resetField(rf_b), .score_h(sh_b), .score_c(sc_b),
        .display_h(dh_b), .display_c(dc_b), .winner(w_b), .match_over(mo_b)
    );

    typedef struct packed {
        logic       rf;
        logic [3:0] sh;
        logic [3:0] sc;
        logic [6:0] dh;
        logic [6:0] dc;
        logic [1:0] w;
        logic       mo;
    } out_t;
    typedef struct packed {
        out_t a;
        out_t b;
    } exp_t;
    typedef struct {
        int st;
        int sh;
        int sc;
        int win;
        int hl;
        int oc;
    } model_t;

    exp_t   sb[$];
    model_t ma = '{default: 0}, mb = '{default: 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    // st: 0 play, 1 hold, 2 over; hl = hold cycles remaining incl. current; oc = cycles spent in over
    function automatic model_t step(input model_t m, input bit rst, nm, le, l, ri, r, input int ws, hc);
        model_t n = m;
        if (rst) return '{default: 0};
        if (nm) return '{st: 1, sh: 0, sc: 0, win: 0, hl: hc, oc: 0};
        if (m.st == 0 && le && l && !r) begin
            n.sh = m.sh + 1;
            if (n.sh == ws) begin n.st = 2; n.win = 1; n.oc = 0; end
            else begin n.st = 1; n.hl = hc; end
        end else if (m.st == 0 && ri && r && !l) begin
            n.sc = m.sc + 1;
            if (n.sc == ws) begin n.st = 2; n.win = 2; n.oc = 0; end
            else begin n.st = 1; n.hl = hc; end
        end else if (m.st == 1) begin
            n.hl = m.hl - 1;
            if (n.hl == 0) n.st = 0;
        end else if (m.st == 2) begin
            n.oc = m.oc + 1;
        end
        return n;
    endfunction

    function automatic out_t mout(input model_t m, input int bh);
        out_t o;
        bit off = (m.st == 2) && ((m.oc / bh) % 2 == 1);
        o.rf = m.st != 0;
        o.mo = m.st == 2;
        o.w  = m.win[1:0];
        o.sh = m.sh[3:0];
        o.sc = m.sc[3:0];
        o.dh = (off && m.win == 1) ? 7'b1111111 : seg(m.sh);
        o.dc = (off && m.win == 2) ? 7'b1111111 : seg(m.sc);
        return o;
    endfunction

    task automatic cyc(input bit rst, nm, le, l, ri, r);
        exp_t e;
        @(negedge clk);
        reset = rst; new_match = nm; leftest = le; L = l; rightest = ri; R = r;
        ma = step(ma, rst, nm, le, l, ri, r, 7, 4);
        mb = step(mb, rst, nm, le, l, ri, r, 3, 1);
        sb.push_back('{a: mout(ma, 8), b: mout(mb, 8)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("a_rf", 32'(rf_a), 32'(e.a.rf));
        chk("a_sh", 32'(sh_a), 32'(e.a.sh));
        chk("a_sc", 32'(sc_a), 32'(e.a.sc));
        chk("a_dh", 32'(dh_a), 32'(e.a.dh));
        chk("a_dc", 32'(dc_a), 32'(e.a.dc));
        chk("a_w", 32'(w_a), 32'(e.a.w));
        chk("a_mo", 32'(mo_a), 32'(e.a.mo));
        chk("b_rf", 32'(rf_b), 32'(e.b.rf));
        chk("b_sh", 32'(sh_b), 32'(e.b.sh));
        chk("b_sc", 32'(sc_b), 32'(e.b.sc));
        chk("b_dh", 32'(dh_b), 32'(e.b.dh));
        chk("b_dc", 32'(dc_b), 32'(e.b.dc));
        chk("b_w", 32'(w_b), 32'(e.b.w));
        chk("b_mo", 32'(mo_b), 32'(e.b.mo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_sh", 32'(sh_a), 0);
        chk("rst_dh", 32'(dh_a), 32'(7'b1000000));
        chk("rst_rf", 32'(rf_a), 0);
        idle(2);
        cyc(0, 0, 1, 1, 0, 0);
        chk("pt_sh", 32'(sh_a), 1);
        chk("pt_dh", 32'(dh_a), 32'(7'b1111001));
        rf_cnt = 32'(rf_a);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            rf_cnt += 32'(rf_a);
        end
        chk("hold_len", rf_cnt, 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 1, 1);
        chk("both_sh", 32'(sh_a), 1);
        chk("both_rf", 32'(rf_a), 0);
        for (int p = 0; p < 7; p++) begin
            cyc(0, 0, 0, 0, 1, 1);
            if (p < 6) idle(4);
        end
        chk("c_win", 32'(w_a), 2);
        chk("c_mo", 32'(mo_a), 1);
        chk("c_rf", 32'(rf_a), 1);
        chk("blink_on", 32'(dc_a), 32'(7'b1111000));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1);
        chk("blink_off", 32'(dc_a), 32'(7'b1111111));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1);
        chk("blink_on2", 32'(dc_a), 32'(7'b1111000));
        chk("frozen_sc", 32'(sc_a), 7);
        cyc(0, 1, 0, 0, 0, 0);
        chk("nm_sc", 32'(sc_a), 0);
        chk("nm_w", 32'(w_a), 0);
        chk("nm_mo", 32'(mo_a), 0);
        chk("nm_rf", 32'(rf_a), 1);
        idle(5);
        cyc(0, 0, 1, 1, 0, 0);
        idle(1);
        cyc(0, 0, 1, 1, 0, 0);
        idle(4);
        chk("hold_press", 32'(sh_a), 1);
        for (int p = 0; p < 6; p++) begin
            cyc(0, 0, 1, 1, 0, 0);
            idle(4);
        end
        chk("h_win", 32'(w_a), 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("ro_sh", 32'(sh_a), 0);
        chk("ro_w", 32'(w_a), 0);
        chk("ro_mo", 32'(mo_a), 0);
        chk("ro_rf", 32'(rf_a), 0);
        chk("ro_dh", 32'(dh_a), 32'(7'b1000000));
        for (int p = 0; p < 3; p++) begin
            cyc(0, 0, 1, 1, 0, 0);
            chk("b_pulse", 32'(rf_b), 1);
            idle(1);
            if (p < 2) chk("b_pulse_end", 32'(rf_b), 0);
        end
        chk("b_win", 32'(w_b), 1);
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
